// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: memory op codes, FSM state encoding,
// and byte-lane helpers for load extraction and alignment checks.
package mem_pkg;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        MOP_LB   = 4'd1,
        MOP_LH   = 4'd2,
        MOP_LW   = 4'd3,
        MOP_LBU  = 4'd4,
        MOP_LHU  = 4'd5,
        MOP_SB   = 4'd6,
        MOP_SH   = 4'd7,
        MOP_SW   = 4'd8
    } mop_e;

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_RMW_WRITE = 1'b1;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [15:0] lane_half(input logic [31:0] w, input logic hi);
        return hi ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    function automatic logic misaligned(input mop_e op, input logic [1:0] off);
        logic m;
        case (op)
            MOP_LH, MOP_LHU, MOP_SH: m = off[0];
            MOP_LW, MOP_SW:          m = |off;
            default:                 m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts/extends load data and merges sub-word
// store data into the word read back from RAM.
module mem_lane_align
    import mem_pkg::*;
(
    input  mop_e        op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    always_comb begin
        load_data = '0;
        case (op)
            MOP_LB:  load_data = extend8(lane_byte(rdata, off), 1'b1);
            MOP_LBU: load_data = extend8(lane_byte(rdata, off), 1'b0);
            MOP_LH:  load_data = extend16(lane_half(rdata, off[1]), 1'b1);
            MOP_LHU: load_data = extend16(lane_half(rdata, off[1]), 1'b0);
            MOP_LW:  load_data = rdata;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merge_data = rdata;
        case (op)
            MOP_SB:  merge_data[{off, 3'b000} +: 8] = wdata[7:0];
            MOP_SH:  merge_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the word-only data RAM, aligns loads, performs
// SB/SH as a two-cycle read-modify-write and registers the MEM/WB result.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int RAM_AW = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [3:0]        in_op,
    input  logic [31:0]       in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [4:0]        in_rd,
    input  logic              in_regwrite,
    input  logic              flush,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign
);

    logic [0:0]        state;
    logic [RAM_AW-1:0] addr_q;
    logic [DATA_W-1:0] merge_q;

    mop_e              op;
    logic [1:0]        off;
    logic [RAM_AW-1:0] idx;
    logic              slot, mis, fault;
    logic              is_load, is_store, is_sub, rmw_start;
    logic              we_c;
    logic [DATA_W-1:0] load_data, merge_data, result;
    logic              unused_addr_bits;

    assign op    = mop_e'(in_op);
    assign off   = in_addr[1:0];
    assign idx   = in_addr[RAM_AW+1:2];
    assign slot  = in_valid && !flush;
    assign mis   = misaligned(op, off);
    assign fault = slot && mis;

    assign is_load  = (op == MOP_LB) || (op == MOP_LH) || (op == MOP_LW) ||
                      (op == MOP_LBU) || (op == MOP_LHU);
    assign is_sub   = (op == MOP_SB) || (op == MOP_SH);
    assign is_store = is_sub || (op == MOP_SW);
    assign rmw_start = (state == ST_IDLE) && slot && is_sub && !mis;
    assign result    = is_load ? load_data : in_alu;

    assign unused_addr_bits = ^in_addr[31:RAM_AW+2];

    mem_lane_align u_align (
        .op         (op),
        .off        (off),
        .rdata      (ram_dout),
        .wdata      (in_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        ram_addr = idx;
        ram_din  = in_wdata;
        we_c     = 1'b0;
        stall    = 1'b0;
        if (state == ST_RMW_WRITE) begin
            ram_addr = addr_q;
            ram_din  = merge_q;
            we_c     = !flush;
        end else begin
            we_c  = slot && (op == MOP_SW) && !mis;
            stall = rmw_start;
        end
    end

    // Gating with rst_n keeps RAM untouched while the pipeline is held in reset.
    assign ram_we = we_c && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            merge_q     <= '0;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            misalign    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    misalign <= fault;
                    if (rmw_start) begin
                        state       <= ST_RMW_WRITE;
                        addr_q      <= idx;
                        merge_q     <= merge_data;
                        wb_valid    <= 1'b0;
                        wb_regwrite <= 1'b0;
                    end else begin
                        wb_valid    <= slot;
                        wb_regwrite <= slot && in_regwrite && (in_rd != '0) &&
                                       !fault && !is_store;
                        if (slot) begin
                            wb_rd   <= in_rd;
                            wb_data <= result;
                        end
                    end
                end
                ST_RMW_WRITE: begin
                    state       <= ST_IDLE;
                    wb_valid    <= !flush;
                    wb_regwrite <= 1'b0;
                    misalign    <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random traffic, checked
// every cycle against a word-array reference model of the stage.
module tb_mem_access_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    mop_e        in_op = MOP_NONE;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [31:0] in_alu = '0;
    logic [4:0]  in_rd = '0;
    logic        in_regwrite = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic        stall;
    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;

    always #5 clk = ~clk;

    mem_access_stage #(.RAM_AW(6), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_alu      (in_alu),
        .in_rd       (in_rd),
        .in_regwrite (in_regwrite),
        .flush       (flush),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_dout    (ram_dout),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .misalign    (misalign)
    );

    logic [31:0] ram [64];
    assign ram_dout = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          we;
        bit          chk_addr;
        logic [5:0]  addr;
        logic [31:0] din;
        bit          chk_stall;
        bit          stall;
        bit          v;
        bit          rw;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          mis;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [31:0] ref_mem [64];
    bit          pend = 0;
    logic [5:0]  pend_idx = '0;
    logic [31:0] pend_word = '0;
    bit          m_v = 0, m_rw = 0, m_mis = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;

    exp_t ce;
    always @(negedge clk) begin
        #2;
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            chk("ram_we", {31'b0, ram_we}, {31'b0, ce.we});
            if (ce.chk_addr) chk("ram_addr", {26'b0, ram_addr}, {26'b0, ce.addr});
            if (ce.we) chk("ram_din", ram_din, ce.din);
            if (ce.chk_stall) chk("stall", {31'b0, stall}, {31'b0, ce.stall});
            chk("wb_valid", {31'b0, wb_valid}, {31'b0, ce.v});
            chk("wb_regwrite", {31'b0, wb_regwrite}, {31'b0, ce.rw});
            chk("misalign", {31'b0, misalign}, {31'b0, ce.mis});
            if (ce.rw) begin
                chk("wb_rd", {27'b0, wb_rd}, {27'b0, ce.rd});
                chk("wb_data", wb_data, ce.data);
            end
        end
    end

    task automatic cycle(input bit v, input mop_e op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] alu,
                         input logic [4:0] rd, input bit rw, input bit fl,
                         input bit rstn, output bit st);
        exp_t        e;
        int          sh;
        logic [5:0]  idx;
        logic [31:0] w, b, h, mask;
        bit          live, mis, isst;
        @(negedge clk);
        in_valid = v; in_op = op; in_addr = a; in_wdata = wd; in_alu = alu;
        in_rd = rd; in_regwrite = rw; flush = fl; rst_n = rstn;
        if (!rstn) begin
            pend = 0; m_v = 0; m_rw = 0; m_mis = 0; m_rd = '0; m_data = '0;
        end
        e.v = m_v; e.rw = m_rw; e.rd = m_rd; e.data = m_data; e.mis = m_mis;
        e.chk_stall = rstn; e.stall = 0; e.we = 0; e.chk_addr = 0; e.addr = '0; e.din = '0;
        st = 0;
        if (rstn && pend) begin
            e.we = !fl; e.chk_addr = 1; e.addr = pend_idx; e.din = pend_word;
            if (!fl) ref_mem[pend_idx] = pend_word;
            m_v = !fl; m_rw = 0; m_mis = 0; pend = 0;
        end else if (rstn) begin
            live = v && !fl;
            idx  = a[7:2];
            sh   = 8 * int'(a[1:0]);
            w    = ref_mem[idx];
            mis  = ((op == MOP_LH || op == MOP_LHU || op == MOP_SH) && a[0]) ||
                   ((op == MOP_LW || op == MOP_SW) && a[1:0] != 2'd0);
            isst = (op == MOP_SB || op == MOP_SH || op == MOP_SW);
            e.chk_addr = live; e.addr = idx; e.din = wd;
            if (live && !mis && (op == MOP_SB || op == MOP_SH)) begin
                mask = (op == MOP_SB) ? 32'hFF : 32'hFFFF;
                pend_word = (w & ~(mask << sh)) | ((wd & mask) << sh);
                pend_idx = idx; pend = 1; e.stall = 1; st = 1;
                m_v = 0; m_rw = 0; m_mis = 0;
            end else begin
                e.we = live && !mis && op == MOP_SW;
                if (e.we) ref_mem[idx] = wd;
                m_v   = live;
                m_mis = live && mis;
                m_rw  = live && rw && rd != 0 && !mis && !isst;
                if (live) begin
                    m_rd = rd;
                    b = (w >> sh) & 32'hFF;
                    h = (w >> sh) & 32'hFFFF;
                    case (op)
                        MOP_LB:  m_data = (b >= 128) ? b - 32'd256 : b;
                        MOP_LH:  m_data = (h >= 32768) ? h - 32'd65536 : h;
                        MOP_LW:  m_data = w;
                        MOP_LBU: m_data = b;
                        MOP_LHU: m_data = h;
                        default: m_data = alu;
                    endcase
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input mop_e op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] alu,
                         input logic [4:0] rd, input bit rw, input bit fl, input bit fl2);
        bit st;
        cycle(v, op, a, wd, alu, rd, rw, fl, 1'b1, st);
        if (st) cycle(v, op, a, wd, alu, rd, rw, fl2, 1'b1, st);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          st;
        logic [31:0] w1, w5, w6;
        for (int i = 0; i < 64; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        cycle(0, MOP_NONE, 0, 0, 0, 0, 0, 0, 1'b0, st);
        cycle(0, MOP_NONE, 0, 0, 0, 0, 0, 0, 1'b0, st);
        chk("reset_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);

        issue(1, MOP_SW, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        chk("sw_word4", ram[4], 32'hDEAD_BEEF);
        issue(1, MOP_LB, 32'h11, 0, 0, 5'd3, 1, 0, 0);
        chk("lb_data", wb_data, 32'hFFFF_FFBE);
        chk("lb_regwrite", {31'b0, wb_regwrite}, 32'd1);
        issue(1, MOP_LBU, 32'h11, 0, 0, 5'd4, 1, 0, 0);
        chk("lbu_data", wb_data, 32'h0000_00BE);
        issue(1, MOP_SB, 32'h12, 32'h55, 0, 0, 0, 0, 0);
        chk("sb_word4", ram[4], 32'hDE55_BEEF);
        issue(1, MOP_LW, 32'h10, 0, 0, 5'd5, 1, 0, 0);
        chk("lw_after_sb", wb_data, 32'hDE55_BEEF);

        w1 = ram[1];
        issue(1, MOP_LW, 32'h06, 0, 0, 5'd6, 1, 0, 0);
        chk("misalign_pulse", {31'b0, misalign}, 32'd1);
        chk("misalign_regwrite", {31'b0, wb_regwrite}, 32'd0);
        issue(0, MOP_NONE, 0, 0, 0, 0, 0, 0, 0);
        chk("misalign_clears", {31'b0, misalign}, 32'd0);
        chk("misalign_ram", ram[1], w1);

        w5 = ram[5];
        issue(1, MOP_SH, 32'h14, 32'h1234, 0, 0, 0, 0, 1);
        chk("sh_flush_valid", {31'b0, wb_valid}, 32'd0);
        chk("sh_flush_ram", ram[5], w5);

        w6 = ram[6];
        cycle(1, MOP_SH, 32'h18, 32'hABCD, 0, 0, 0, 0, 1'b1, st);
        chk("rmw_stall_seen", {31'b0, st}, 32'd1);
        cycle(0, MOP_NONE, 0, 0, 0, 0, 0, 0, 1'b0, st);
        chk("midrst_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("midrst_wb_data", wb_data, 32'd0);
        cycle(0, MOP_NONE, 0, 0, 0, 0, 0, 0, 1'b1, st);
        chk("midrst_ram", ram[6], w6);
        issue(1, MOP_LW, 32'h18, 0, 0, 5'd0, 1, 0, 0);
        chk("lw_rd0_regwrite", {31'b0, wb_regwrite}, 32'd0);
        chk("lw_rd0_valid", {31'b0, wb_valid}, 32'd1);

        for (int n = 0; n < 400; n++) begin
            issue($urandom_range(0, 7) != 0,
                  mop_e'(4'($urandom_range(0, 8))),
                  $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 31)),
                  $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0);
        end
        issue(0, MOP_NONE, 0, 0, 0, 0, 0, 0, 0);
        issue(0, MOP_NONE, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) chk($sformatf("ram_word%0d", i), ram[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
